// File: rtl/ball_kinematics.sv
// Pong ball kinematics: position/velocity registers, serve/move/score FSM,
// LFSR-driven serve direction, paddle/wall reflection and paddle-hit speedup.
module ball_kinematics #(
  parameter int         POS_W        = 6,
  parameter int         FIELD_W      = 64,
  parameter int         FIELD_H      = 64,
  parameter int         BALL_SIZE    = 2,
  parameter int         VEL_W        = 4,
  parameter int         V_INIT       = 1,
  parameter int         V_MAX        = 4,
  parameter int         SPEEDUP_HITS = 4,
  parameter int         SERVE_DELAY  = 16,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    serve_req,
  input  logic                    paddle_hit,
  input  logic                    wall_hit,
  output logic [POS_W-1:0]        bx,
  output logic [POS_W-1:0]        by,
  output logic signed [VEL_W-1:0] vx,
  output logic signed [VEL_W-1:0] vy,
  output logic                    moving,
  output logic                    score_p1,
  output logic                    score_p2,
  output logic [1:0]              state
);
  localparam int SW    = POS_W + 2;
  localparam int CNT_W = $clog2(SPEEDUP_HITS + 1);
  localparam int DLY_W = $clog2(SERVE_DELAY + 2);

  localparam logic [POS_W-1:0]        CX      = POS_W'((FIELD_W - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0]        CY      = POS_W'((FIELD_H - BALL_SIZE) / 2);
  localparam logic signed [SW-1:0]    XMAX    = SW'(FIELD_W - BALL_SIZE);
  localparam logic signed [SW-1:0]    YMAX    = SW'(FIELD_H - BALL_SIZE);
  localparam logic signed [VEL_W-1:0] VINIT_V = VEL_W'(V_INIT);
  localparam logic signed [VEL_W-1:0] VMAX_V  = VEL_W'(V_MAX);
  localparam logic signed [VEL_W-1:0] VONE    = VEL_W'(1);
  localparam logic signed [VEL_W-1:0] VTWO    = VEL_W'(2);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    MOVE       = 2'd2,
    SCORED     = 2'd3
  } state_t;

  function automatic logic signed [VEL_W-1:0] vabs(input logic signed [VEL_W-1:0] v);
    return v[VEL_W-1] ? -v : v;
  endfunction

  state_t                   state_q, state_d;
  logic [POS_W-1:0]         bx_q, bx_d, by_q, by_d;
  logic signed [VEL_W-1:0]  vx_q, vx_d, vy_q, vy_d;
  logic [CNT_W-1:0]         hits_q, hits_d;
  logic [DLY_W-1:0]         dly_q, dly_d;
  logic [7:0]               lfsr_q, lfsr_d;
  logic                     p1_q, p1_d, p2_q, p2_d;

  logic [CNT_W-1:0]         hits_inc;
  logic                     speedup;
  logic signed [VEL_W-1:0]  vx_mag, vx_post, vy_wall, vy_launch;
  logic signed [SW-1:0]     bx_ext, by_ext, nx_raw, nx, ny;
  logic                     raw_out, post_out, exit_left;

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    hits_d  = hits_q;
    dly_d   = dly_q;
    p1_d    = 1'b0;
    p2_d    = 1'b0;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    hits_inc = hits_q + 1'b1;
    speedup  = paddle_hit && (hits_inc == CNT_W'(SPEEDUP_HITS));
    vx_mag   = vabs(vx_q);
    if (speedup) vx_mag = (vx_mag >= VMAX_V) ? VMAX_V : vx_mag + VONE;
    vx_post  = paddle_hit ? (vx_q[VEL_W-1] ? vx_mag : -vx_mag) : vx_q;
    vy_wall  = wall_hit ? -vy_q : vy_q;

    vy_launch = lfsr_q[2] ? VTWO : VONE;
    if (vy_launch > VMAX_V) vy_launch = VMAX_V;

    bx_ext    = SW'({2'b00, bx_q});
    by_ext    = SW'({2'b00, by_q});
    nx_raw    = bx_ext + SW'(vx_q);
    nx        = bx_ext + SW'(vx_post);
    ny        = by_ext + SW'(vy_wall);
    // An exit along the incoming velocity wins over a same-tick paddle bounce
    raw_out   = nx_raw[SW-1] || (nx_raw > XMAX);
    post_out  = nx[SW-1] || (nx > XMAX);
    exit_left = raw_out ? nx_raw[SW-1] : nx[SW-1];

    unique case (state_q)
      IDLE: begin
        if (serve_req) begin
          state_d = SERVE_WAIT;
          dly_d   = DLY_W'(SERVE_DELAY);
        end
      end
      SERVE_WAIT: begin
        if (tick) begin
          if (dly_q == '0) begin
            vx_d    = lfsr_q[0] ? VINIT_V : -VINIT_V;
            vy_d    = lfsr_q[3] ? -vy_launch : vy_launch;
            state_d = MOVE;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
      end
      MOVE: begin
        if (tick) begin
          if (ny[SW-1]) begin
            by_d = '0;
            vy_d = vabs(vy_wall);
          end else if (ny > YMAX) begin
            by_d = YMAX[POS_W-1:0];
            vy_d = -vabs(vy_wall);
          end else begin
            by_d = ny[POS_W-1:0];
            vy_d = vy_wall;
          end
          if (!raw_out && paddle_hit) begin
            vx_d   = vx_post;
            hits_d = speedup ? '0 : hits_inc;
          end
          if (raw_out || post_out) begin
            state_d = SCORED;
            bx_d    = exit_left ? '0 : XMAX[POS_W-1:0];
            p2_d    = exit_left;
            p1_d    = !exit_left;
          end else begin
            bx_d = nx[POS_W-1:0];
          end
        end
      end
      SCORED: begin
        state_d = SERVE_WAIT;
        dly_d   = DLY_W'(SERVE_DELAY);
        bx_d    = CX;
        by_d    = CY;
        vx_d    = '0;
        vy_d    = '0;
        hits_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bx_q    <= CX;
      by_q    <= CY;
      vx_q    <= '0;
      vy_q    <= '0;
      hits_q  <= '0;
      dly_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      hits_q  <= hits_d;
      dly_q   <= dly_d;
      lfsr_q  <= lfsr_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end

  assign bx       = bx_q;
  assign by       = by_q;
  assign vx       = vx_q;
  assign vy       = vy_q;
  assign moving   = (state_q == MOVE);
  assign score_p1 = p1_q;
  assign score_p2 = p2_q;
  assign state    = state_q;

endmodule

// File: tb/tb_ball_kinematics.sv
// Self-checking bench for ball_kinematics: integer-level game model driven
// alongside the DUT with directed scenarios and randomized tick/hit traffic.
module tb_ball_kinematics;
  localparam int POS_W = 6, FIELD_W = 64, FIELD_H = 64, BALL_SIZE = 2, VEL_W = 4;
  localparam int V_INIT = 1, V_MAX = 4, SPEEDUP_HITS = 4, SERVE_DELAY = 16;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam int CX = (FIELD_W - BALL_SIZE) / 2, CY = (FIELD_H - BALL_SIZE) / 2;
  localparam int XMAX = FIELD_W - BALL_SIZE, YMAX = FIELD_H - BALL_SIZE;
  localparam int VEC_W = 2 * POS_W + 2 * VEL_W + 5;

  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, serve_req = 1'b0;
  logic paddle_hit = 1'b0, wall_hit = 1'b0;
  logic [POS_W-1:0] bx, by;
  logic signed [VEL_W-1:0] vx, vy;
  logic moving, score_p1, score_p2;
  logic [1:0] state;
  logic [VEC_W-1:0] act_vec;

  int errors = 0, checks = 0;

  int m_state, m_bx, m_by, m_vx, m_vy, m_hits, m_dly;
  logic [7:0] m_lfsr;
  bit m_p1, m_p2;

  ball_kinematics #(
    .POS_W(POS_W), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .BALL_SIZE(BALL_SIZE),
    .VEL_W(VEL_W), .V_INIT(V_INIT), .V_MAX(V_MAX), .SPEEDUP_HITS(SPEEDUP_HITS),
    .SERVE_DELAY(SERVE_DELAY), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .serve_req(serve_req),
    .paddle_hit(paddle_hit), .wall_hit(wall_hit), .bx(bx), .by(by),
    .vx(vx), .vy(vy), .moving(moving), .score_p1(score_p1),
    .score_p2(score_p2), .state(state)
  );

  always #5 clk = ~clk;
  assign act_vec = {bx, by, vx, vy, moving, score_p1, score_p2, state};

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = 0; m_bx = CX; m_by = CY; m_vx = 0; m_vy = 0;
    m_hits = 0; m_dly = 0; m_lfsr = LFSR_SEED; m_p1 = 0; m_p2 = 0;
  endtask

  task automatic model_score(input int x);
    m_state = 3;
    if (x < 0) begin m_bx = 0;    m_p2 = 1; end
    else       begin m_bx = XMAX; m_p1 = 1; end
  endtask

  // One clock of the game rules, applied to plain integers.
  task automatic model_clk(input bit srv, input bit tk, input bit ph, input bit wh);
    logic [7:0] l;
    int mag, vyn, ny, nxr, vxn, nx;
    l = m_lfsr;
    m_lfsr = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    m_p1 = 0; m_p2 = 0;
    case (m_state)
      0: if (srv) begin m_state = 1; m_dly = SERVE_DELAY; end
      1: if (tk) begin
        if (m_dly == 0) begin
          m_vx = l[0] ? V_INIT : -V_INIT;
          mag = imin(1 + int'(l[2]), V_MAX);
          m_vy = l[3] ? -mag : mag;
          m_state = 2;
        end else m_dly--;
      end
      2: if (tk) begin
        vyn = wh ? -m_vy : m_vy;
        ny = m_by + vyn;
        if (ny < 0)         begin m_by = 0;    m_vy = iabs(vyn);  end
        else if (ny > YMAX) begin m_by = YMAX; m_vy = -iabs(vyn); end
        else                begin m_by = ny;   m_vy = vyn;        end
        nxr = m_bx + m_vx;
        if (nxr < 0 || nxr > XMAX) model_score(nxr);
        else begin
          vxn = m_vx;
          if (ph) begin
            mag = iabs(m_vx);
            m_hits++;
            if (m_hits == SPEEDUP_HITS) begin m_hits = 0; mag = imin(mag + 1, V_MAX); end
            vxn = (m_vx > 0) ? -mag : mag;
          end
          m_vx = vxn;
          nx = m_bx + vxn;
          if (nx < 0 || nx > XMAX) model_score(nx);
          else m_bx = nx;
        end
      end
      default: begin
        m_state = 1; m_dly = SERVE_DELAY; m_bx = CX; m_by = CY;
        m_vx = 0; m_vy = 0; m_hits = 0;
      end
    endcase
  endtask

  function automatic logic [VEC_W-1:0] exp_vec();
    logic [POS_W-1:0] ebx, eby;
    logic [VEL_W-1:0] evx, evy;
    ebx = POS_W'(m_bx); eby = POS_W'(m_by);
    evx = VEL_W'(m_vx); evy = VEL_W'(m_vy);
    return {ebx, eby, evx, evy, (m_state == 2), m_p1, m_p2, 2'(m_state)};
  endfunction

  task automatic step(input bit t, input bit s, input bit p, input bit w);
    tick = t; serve_req = s; paddle_hit = p; wall_hit = w;
    @(posedge clk);
    model_clk(s, t, p, w);
    #1;
  endtask

  task automatic test_reset();
    if ({bx, by} !== {6'd31, 6'd31}) begin errors++; $display("FAIL reset_pos: got bx=%0d by=%0d want 31 31", bx, by); end
    checks++;
    if ({vx, vy, state, moving, score_p1, score_p2} !== 13'd0) begin
      errors++; $display("FAIL reset_ctl: got vx=%0d vy=%0d st=%0d mv=%b p1=%b p2=%b want zeros", vx, vy, state, moving, score_p1, score_p2);
    end
    checks++;
  endtask

  task automatic test_serve();
    step(0, 1, 0, 0);
    if (state !== 2'd1) begin errors++; $display("FAIL serve_accept: got state=%0d want 1", state); end
    checks++;
    for (int i = 1; i <= SERVE_DELAY; i++) begin
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      if (state !== 2'd1 || bx !== 6'd31 || by !== 6'd31) begin
        errors++; $display("FAIL serve_wait%0d: got state=%0d bx=%0d by=%0d want 1 31 31", i, state, bx, by);
      end
      checks++;
    end
    step(1, 0, 0, 0);
    if (state !== 2'd2 || !moving || bx !== 6'd31 || by !== 6'd31) begin
      errors++; $display("FAIL serve_launch: got state=%0d mv=%b bx=%0d by=%0d want 2 1 31 31", state, moving, bx, by);
    end
    checks++;
    if (iabs(int'(vx)) != V_INIT || !(iabs(int'(vy)) inside {1, 2})) begin
      errors++; $display("FAIL serve_vel: got vx=%0d vy=%0d want |vx|=1 |vy| in 1..2", vx, vy);
    end
    checks++;
    if (act_vec !== exp_vec()) begin errors++; $display("FAIL serve_model: got %h want %h", act_vec, exp_vec()); end
    checks++;
  endtask

  task automatic test_speedup();
    int pvx, want;
    for (int k = 1; k <= 16; k++) begin
      pvx = m_vx;
      step(1, 0, 1, 0);
      want = imin(V_INIT + k / SPEEDUP_HITS, V_MAX);
      if (iabs(int'(vx)) != want || (int'(vx) > 0) == (pvx > 0)) begin
        errors++; $display("FAIL speedup_hit%0d: got vx=%0d want |vx|=%0d opposite sign of %0d", k, vx, want, pvx);
      end
      checks++;
      if (act_vec !== exp_vec()) begin errors++; $display("FAIL speedup_model%0d: got %h want %h", k, act_vec, exp_vec()); end
      checks++;
    end
  endtask

  task automatic test_both_hits();
    int pvx, pvy, pbx, pby;
    pvx = m_vx; pvy = m_vy; pbx = m_bx; pby = m_by;
    step(1, 0, 1, 1);
    if (int'(vx) != -pvx || int'(bx) != pbx - pvx) begin
      errors++; $display("FAIL both_x: got vx=%0d bx=%0d want %0d %0d", vx, bx, -pvx, pbx - pvx);
    end
    checks++;
    if (pby - pvy >= 0 && pby - pvy <= YMAX) begin
      if (int'(vy) != -pvy || int'(by) != pby - pvy) begin
        errors++; $display("FAIL both_y: got vy=%0d by=%0d want %0d %0d", vy, by, -pvy, pby - pvy);
      end
      checks++;
    end
    if (act_vec !== exp_vec()) begin errors++; $display("FAIL both_model: got %h want %h", act_vec, exp_vec()); end
    checks++;
  endtask

  // Run the ball out of the field; returns 1 if the right edge was crossed.
  task automatic run_to_score(input string tag, output bit right);
    int n;
    n = 0;
    right = 0;
    while (!(score_p1 || score_p2) && n < 300) begin
      right = (m_vx > 0);
      step(1, 0, 0, 0);
      if (act_vec !== exp_vec()) begin errors++; $display("FAIL %s_model: got %h want %h", tag, act_vec, exp_vec()); end
      checks++;
      n++;
    end
    if (!(score_p1 || score_p2)) begin errors++; $display("FAIL %s_timeout: no score pulse within 300 ticks", tag); end
    checks++;
    if (state !== 2'd3 || score_p1 !== right || score_p2 !== !right) begin
      errors++; $display("FAIL %s_pulse: got state=%0d p1=%b p2=%b want 3 %b %b", tag, state, score_p1, score_p2, right, !right);
    end
    checks++;
    step(0, 0, 0, 0);
    if (state !== 2'd1 || bx !== 6'd31 || by !== 6'd31 || vx !== 4'sd0 || vy !== 4'sd0 || score_p1 || score_p2) begin
      errors++; $display("FAIL %s_reserve: got st=%0d bx=%0d by=%0d vx=%0d vy=%0d p1=%b p2=%b want 1 31 31 0 0 0 0",
                        tag, state, bx, by, vx, vy, score_p1, score_p2);
    end
    checks++;
  endtask

  task automatic wait_moving(input string tag);
    int n;
    n = 0;
    while (!moving && n < 100) begin
      step(1, 0, 0, 0);
      n++;
    end
    if (!moving) begin errors++; $display("FAIL %s_launch: got state=%0d want 2 within 100 ticks", tag, state); end
    checks++;
    if (act_vec !== exp_vec()) begin errors++; $display("FAIL %s_launchmodel: got %h want %h", tag, act_vec, exp_vec()); end
    checks++;
  endtask

  task automatic test_score();
    bit first, second;
    run_to_score("score_a", first);
    wait_moving("score_b");
    if ((m_vx > 0) == first) step(1, 0, 1, 0);
    run_to_score("score_b", second);
    if (second == first) begin errors++; $display("FAIL score_sides: got right=%b twice want both edges", first); end
    checks++;
  endtask

  task automatic test_random();
    bit t, s, p, w;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 9) == 0);
      w = ($urandom_range(0, 9) == 0);
      step(t, s, p, w);
      if (act_vec !== exp_vec()) begin errors++; $display("FAIL random_c%0d: got %h want %h", i, act_vec, exp_vec()); end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    wait_moving("areset");
    step(0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    if ({bx, by} !== {6'd31, 6'd31} || {vx, vy, state, moving, score_p1, score_p2} !== 13'd0) begin
      errors++; $display("FAIL areset_outputs: got bx=%0d by=%0d vx=%0d vy=%0d st=%0d mv=%b want 31 31 0 0 0 0",
                        bx, by, vx, vy, state, moving);
    end
    checks++;
    model_reset();
    @(negedge clk) reset = 1'b0;
    step(0, 1, 0, 0);
    if (state !== 2'd1) begin errors++; $display("FAIL areset_serve: got state=%0d want 1", state); end
    checks++;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0);
      if (act_vec !== exp_vec()) begin errors++; $display("FAIL areset_model%0d: got %h want %h", i, act_vec, exp_vec()); end
      checks++;
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    test_reset();
    test_serve();
    test_speedup();
    test_both_hits();
    test_score();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_kinematics.md
Name: ball_kinematics

Overview:
Parametrised successor to the Pong ball-movement logic. Owns ball position and signed velocity, runs a serve/move/score state machine, and serves the ball after a delay in a pseudo-random non-zero direction. Reflects on paddle and wall hits, with simultaneous hits allowed, and speeds the ball up after repeated paddle hits. Sits between collision detection (hit flags in) and the renderer/scoreboard (position and score pulses out).

Parameters:
POS_W, 6, width of bx/by (unsigned pixels)
FIELD_W, 64, playfield width in pixels
FIELD_H, 64, playfield height in pixels
BALL_SIZE, 2, ball edge length in pixels
VEL_W, 4, width of signed vx/vy (two's complement)
V_INIT, 1, |vx| at serve
V_MAX, 4, saturation limit for |vx| and |vy|; must be < 2^(VEL_W-1)
SPEEDUP_HITS, 4, paddle hits per +1 increment of |vx|
SERVE_DELAY, 16, ticks from serve request/score to launch
LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  motion enable (frame tick); all motion and delay counting is qualified by it
serve_req  in  1  start a game from IDLE
paddle_hit  in  1  paddle collision flag, sampled only when tick=1
wall_hit  in  1  top/bottom wall collision flag, sampled only when tick=1
bx  out  POS_W  ball x (left edge)
by  out  POS_W  ball y (top edge)
vx  out  VEL_W  signed x velocity
vy  out  VEL_W  signed y velocity
moving  out  1  high while state is MOVE
score_p1  out  1  one-clk pulse: ball exited the right edge
score_p2  out  1  one-clk pulse: ball exited the left edge
state  out  2  IDLE=0, SERVE_WAIT=1, MOVE=2, SCORED=3

Behaviour:
- Reset (async, immediate, also mid-flight):
  - bx=CX=(FIELD_W-BALL_SIZE)/2 and by=CY=(FIELD_H-BALL_SIZE)/2.
  - vx=vy=0, state=IDLE, score pulses=0, hit counter=0, delay counter=0, LFSR=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts every clk regardless of tick or state. Never reaches zero.
- IDLE:
  - serve_req=1 -> SERVE_WAIT with delay=SERVE_DELAY.
  - serve_req is ignored in every other state.
- SERVE_WAIT:
  - On each tick, delay decrements.
  - On the tick where delay==0, launch using current LFSR bits:
    - vx = lfsr[0] ? +V_INIT : -V_INIT
    - vy magnitude = min(1+lfsr[2], V_MAX), sign = lfsr[3] (1 = negative)
    - State -> MOVE. Position does not change on the launch tick.
- MOVE: all updates happen only on tick cycles; with tick=0, everything holds.
  - paddle_hit: vx negates, and the hit counter increments.
    - When the counter reaches SPEEDUP_HITS it clears, and |vx| grows by 1, saturating at V_MAX, sign preserved.
  - wall_hit: vy negates.
  - paddle_hit and wall_hit on the same tick: both apply.
  - Position advances on the same tick using the post-reflection velocity: nx=bx+vx, ny=by+vy.
    - Compute at POS_W+2 signed width. No wrap-around is permitted.
  - Y bounds:
    - ny<0 -> by=0, vy=+|vy|.
    - ny>FIELD_H-BALL_SIZE -> by=FIELD_H-BALL_SIZE, vy=-|vy|.
    - This auto-reflection applies even if wall_hit is absent.
  - X exit:
    - nx<0 -> bx=0, state=SCORED, score_p2=1.
    - nx>FIELD_W-BALL_SIZE -> bx=FIELD_W-BALL_SIZE, state=SCORED, score_p1=1.
    - X exit takes priority over paddle reflection on the same tick: the score stands.
- SCORED: lasts exactly one clk.
  - score_p1/score_p2 are high only during this cycle.
  - bx/by reset to CX/CY, vx=vy=0, hit counter cleared.
  - Next state is SERVE_WAIT with delay=SERVE_DELAY (automatic re-serve).
- Outputs are all registered. moving is decoded from registered state.

Test Plan:
- Reset, then serve_req with SERVE_DELAY=16 -> state goes IDLE->SERVE_WAIT; MOVE entered on the 17th tick; |vx|=1, vy∈{±1,±2}; bx=by=31 until the first MOVE tick.
- Force vx=+1, vy=-1, by=0 in MOVE; tick -> by=0, vy=+1 (auto wall reflect); bx increments by 1.
- Four paddle_hit ticks with SPEEDUP_HITS=4 -> vx sign alternates; |vx| becomes 2 after the 4th hit. Continued hits saturate |vx| at V_MAX=4.
- paddle_hit and wall_hit together on one tick, with vx=+2, vy=+1 -> vx=-2, vy=-1, and position moves by (-2,-1) that tick.
- Ball at bx=1, vx=-2, tick -> one-clk score_p2 pulse, state=SCORED, then SERVE_WAIT; bx=by=31, vx=vy=0. Repeat on the right edge for score_p1.
- Assert reset during MOVE with tick idle -> all outputs return to reset values in the same cycle without a clock edge. A subsequent serve_req is accepted normally.
